// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: pipelined address/data phases, programmable wait states, two-cycle ERROR.
// Define AHB_SLV_RAND_WAIT_EN to draw each OKAY wait count from a 16-bit LFSR instead of WAIT_STATES.
module ahb_slave_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);

  localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] WIN_BYTES = 32'(MEM_DEPTH * 4);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        lo_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic              hready_q;
  logic [1:0]        hresp_q;
  logic [31:0]       hrdata_q;
  logic [31:0]       mem [MEM_DEPTH];

  logic [31:0]       off;
  logic              in_range, misalign, samp_err, sample;
  logic [IDX_W-1:0]  samp_idx, rd_idx;
  logic [3:0]        wait_cnt, be;
  logic [31:0]       mask, wr_word, rd_word;
  logic              wr_commit, rd_from_wait, rd_load;
  logic              unused_ok;

  assign unused_ok = ^{Hburst, Htrans[0]};

  assign off      = Haddr - ADDR_BASE;
  assign in_range = (Haddr >= ADDR_BASE) && (off < WIN_BYTES);
  assign misalign = ((Hsize == 3'b001) && Haddr[0]) ||
                    ((Hsize == 3'b010) && (Haddr[1:0] != 2'b00));
  assign samp_err = !in_range || (Hsize > 3'b010) || misalign;
  assign sample   = hready_q && Hreadyin && Htrans[1];
  assign samp_idx = off[IDX_W+1:2];

`ifdef AHB_SLV_RAND_WAIT_EN
  logic [15:0] lfsr_q;
  assign wait_cnt = 4'(lfsr_q[3:0] % 5'(WAIT_STATES + 1));
`else
  assign wait_cnt = 4'(WAIT_STATES);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_LAST;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (sample) begin
          if (samp_err) begin
            state_d = S_ERR1;
          end else if (wait_cnt == 4'd0) begin
            state_d = S_LAST;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_cnt;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Little-endian lane enables from the latched address/size of the data phase.
  always_comb begin
    case (size_q)
      3'b000:  be = 4'b0001 << lo_q;
      3'b001:  be = lo_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign mask         = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr_commit    = (state_q == S_LAST) && write_q;
  assign wr_word      = (mem[idx_q] & ~mask) | (Hwdata & mask);
  assign rd_from_wait = (state_q == S_WAIT);
  assign rd_idx       = rd_from_wait ? idx_q : samp_idx;
  assign rd_load      = (state_d == S_LAST) && (rd_from_wait ? !write_q : !Hwrite);
  // A pipelined read of the word being written this edge must see the merged data.
  assign rd_word      = (wr_commit && (rd_idx == idx_q)) ? wr_word : mem[rd_idx];

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      lo_q     <= 2'b00;
      size_q   <= 3'b000;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      hrdata_q <= 32'h0;
`ifdef AHB_SLV_RAND_WAIT_EN
      lfsr_q   <= 16'hACE1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= !((state_d == S_WAIT) || (state_d == S_ERR1));
      hresp_q  <= ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
      if (sample) begin
        idx_q   <= samp_idx;
        lo_q    <= Haddr[1:0];
        size_q  <= Hsize;
        write_q <= Hwrite;
`ifdef AHB_SLV_RAND_WAIT_EN
        lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
      end
      if (rd_load) hrdata_q <= rd_word;
    end
  end

  always_ff @(posedge Hclk) begin
    if (wr_commit) mem[idx_q] <= wr_word;
  end

  assign Hreadyout = hready_q;
  assign Hresp     = hresp_q;
  assign Hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one instance with WAIT_STATES=1, one with WAIT_STATES=0,
// sharing the same bus stimulus; the selected instance drives Hreadyin and is checked.
module tb_ahb_slave_mem;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        rdy1, rdy0;
  logic [1:0]  resp1, resp0;
  logic [31:0] rdata1, rdata0;
  logic        use0;
  logic        b_rdy;
  logic [1:0]  b_resp;
  logic [31:0] b_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 Hclk = ~Hclk;

  assign b_rdy    = use0 ? rdy0   : rdy1;
  assign b_resp   = use0 ? resp0  : resp1;
  assign b_rdata  = use0 ? rdata0 : rdata1;
  assign Hreadyin = b_rdy;

  ahb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(rdy1), .Hresp(resp1), .Hrdata(rdata1));

  ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(rdy0), .Hresp(resp0), .Hrdata(rdata0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single NONSEQ transfer; returns low-ready cycles, first/last response and Hrdata at completion.
  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output int lows, output logic [1:0] r1st,
                      output logic [1:0] rend, output logic [31:0] rd);
    Htrans = 2'b10; Hwrite = wr; Hsize = sz; Haddr = a;
    @(posedge Hclk); #1;
    Htrans = 2'b00; Hwdata = wd;
    r1st = b_resp;
    lows = 0;
    while (b_rdy !== 1'b1 && lows < 32) begin
      lows++;
      @(posedge Hclk); #1;
    end
    rend = b_resp;
    rd   = b_rdata;
    @(posedge Hclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lows;
    logic [1:0]  r1, re;
    logic [31:0] rd;

    use0 = 1'b0; Hresetn = 1'b0; Htrans = 2'b00; Hwrite = 1'b0; Hsize = 3'b010;
    Hburst = 3'b000; Haddr = 32'h0; Hwdata = 32'h0;

    // 1: reset
    repeat (3) @(posedge Hclk);
    #1;
    chk("rst_rdy_ws1", 32'(rdy1), 32'd1);
    chk("rst_resp_ws1", 32'(resp1), 32'd0);
    chk("rst_rdata_ws1", rdata1, 32'h0);
    chk("rst_rdy_ws0", 32'(rdy0), 32'd1);
    chk("rst_resp_ws0", 32'(resp0), 32'd0);
    chk("rst_rdata_ws0", rdata0, 32'h0);
    Hresetn = 1'b1;
    @(posedge Hclk); #1;

    // 2: word write / read with one wait state
    xfer(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, lows, r1, re, rd);
    chk("wr_lows", 32'(lows), 32'd1);
    chk("wr_resp", 32'(re), 32'd0);
    xfer(1'b0, 3'b010, 32'h8000_0010, 32'h0, lows, r1, re, rd);
    chk("rd_lows", 32'(lows), 32'd1);
    chk("rd_resp", 32'(re), 32'd0);
    chk("rd_data", rd, 32'hDEAD_BEEF);

    // 3: byte and halfword lane merging, last word of window
    xfer(1'b1, 3'b010, 32'h8000_0010, 32'h1122_3344, lows, r1, re, rd);
    xfer(1'b1, 3'b000, 32'h8000_0013, 32'h5A00_0000, lows, r1, re, rd);
    xfer(1'b0, 3'b010, 32'h8000_0010, 32'h0, lows, r1, re, rd);
    chk("byte_merge", rd, 32'h5A22_3344);
    xfer(1'b1, 3'b001, 32'h8000_0012, 32'h9876_0000, lows, r1, re, rd);
    xfer(1'b0, 3'b010, 32'h8000_0010, 32'h0, lows, r1, re, rd);
    chk("half_merge", rd, 32'h9876_3344);
    xfer(1'b1, 3'b010, 32'h8000_03FC, 32'h0F0F_0F0F, lows, r1, re, rd);
    chk("top_wr_resp", 32'(re), 32'd0);
    xfer(1'b0, 3'b010, 32'h8000_03FC, 32'h0, lows, r1, re, rd);
    chk("top_rd_data", rd, 32'h0F0F_0F0F);

    // 4: error responses leave memory and Hrdata untouched
    xfer(1'b1, 3'b010, 32'h8000_0000, 32'hCAFE_F00D, lows, r1, re, rd);
    xfer(1'b0, 3'b010, 32'h8000_0000, 32'h0, lows, r1, re, rd);
    chk("base_rd", rd, 32'hCAFE_F00D);
    xfer(1'b0, 3'b010, 32'h8000_0400, 32'h0, lows, r1, re, rd);
    chk("oor_lows", 32'(lows), 32'd1);
    chk("oor_resp1", 32'(r1), 32'd1);
    chk("oor_resp2", 32'(re), 32'd1);
    chk("oor_rdata_held", rd, 32'hCAFE_F00D);
    xfer(1'b1, 3'b010, 32'h8000_0002, 32'hFFFF_FFFF, lows, r1, re, rd);
    chk("mis_lows", 32'(lows), 32'd1);
    chk("mis_resp1", 32'(r1), 32'd1);
    chk("mis_resp2", 32'(re), 32'd1);
    xfer(1'b1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, lows, r1, re, rd);
    chk("size_err", 32'(re), 32'd1);
    xfer(1'b1, 3'b001, 32'h8000_0001, 32'hFFFF_FFFF, lows, r1, re, rd);
    chk("half_mis_err", 32'(re), 32'd1);
    xfer(1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, lows, r1, re, rd);
    chk("below_base_err", 32'(re), 32'd1);
    xfer(1'b0, 3'b010, 32'h8000_0000, 32'h0, lows, r1, re, rd);
    chk("base_unchanged", rd, 32'hCAFE_F00D);
    chk("base_ok_resp", 32'(re), 32'd0);

    // 6: reset during the wait state of a write drops the write
    Htrans = 2'b10; Hwrite = 1'b1; Hsize = 3'b010; Haddr = 32'h8000_0010;
    @(posedge Hclk); #1;
    chk("abort_in_wait", 32'(b_rdy), 32'd0);
    Htrans = 2'b00; Hwdata = 32'h1234_5678;
    #2;
    Hresetn = 1'b0;
    #1;
    chk("abort_rdy", 32'(b_rdy), 32'd1);
    chk("abort_resp", 32'(b_resp), 32'd0);
    chk("abort_rdata", b_rdata, 32'h0);
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
    xfer(1'b0, 3'b010, 32'h8000_0010, 32'h0, lows, r1, re, rd);
    chk("abort_old_data", rd, 32'h9876_3344);

    // 5: zero wait states, write followed by a pipelined same-address read
    use0 = 1'b1;
    #1;
    Htrans = 2'b10; Hwrite = 1'b1; Hsize = 3'b010; Haddr = 32'h8000_0020;
    @(posedge Hclk); #1;
    chk("ws0_wr_rdy", 32'(b_rdy), 32'd1);
    Hwdata = 32'hA5A5_0001; Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8000_0020;
    @(posedge Hclk); #1;
    chk("ws0_rd_rdy", 32'(b_rdy), 32'd1);
    chk("ws0_rd_resp", 32'(b_resp), 32'd0);
    chk("ws0_bypass", b_rdata, 32'hA5A5_0001);
    Htrans = 2'b00;
    @(posedge Hclk); #1;
    xfer(1'b0, 3'b010, 32'h8000_0020, 32'h0, lows, r1, re, rd);
    chk("ws0_rd_lows", 32'(lows), 32'd0);
    chk("ws0_rd_data", rd, 32'hA5A5_0001);
    xfer(1'b0, 3'b010, 32'h8000_0401, 32'h0, lows, r1, re, rd);
    chk("ws0_err_lows", 32'(lows), 32'd1);
    chk("ws0_err_resp", 32'(re), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
